// File: rtl/hgcal_fc_pkg.sv
// Shared encodings for the HGCAL fast-control scheduler: 4-bit symbol codes,
// 3-bit slow-command request codes, the symbol prefix and the Idle symbol.
package hgcal_fc_pkg;

    // Every fast-control symbol is {prefix, code, 1'b1}
    localparam logic [2:0] FC_PREFIX      = 3'b110;
    localparam logic [7:0] FC_IDLE_SYMBOL = 8'hC1;

    // 4-bit codes carried in symbol bits [4:1]
    typedef enum logic [3:0] {
        SYM_IDLE          = 4'b0000,
        SYM_ORBIT_SYNC    = 4'b0001,
        SYM_DAQ_RESYNC    = 4'b0010,
        SYM_L1A           = 4'b0100,
        SYM_L1A_OS        = 4'b0101,
        SYM_OCR_OS        = 4'b0111,
        SYM_CAL_REQ       = 4'b1000,
        SYM_CAL_REQ_L1A   = 4'b1001,
        SYM_CAL_L1A_L1A   = 4'b1010,
        SYM_INTERNAL_TEST = 4'b1011,
        SYM_LINK_RESET    = 4'b1111
    } fc_sym_e;

    // Slow-command request codes on cmd_code (6 and 7 are illegal)
    typedef enum logic [2:0] {
        REQ_LINK_RESET        = 3'd0,
        REQ_DAQ_RESYNC        = 3'd1,
        REQ_CAL_REQ           = 3'd2,
        REQ_INTERNAL_TEST     = 3'd3,
        REQ_ORBIT_COUNT_RESET = 3'd4,
        REQ_CAL_L1A           = 3'd5
    } fc_req_e;

    // Assemble the full 8-bit symbol from a code
    function automatic logic [7:0] fc_symbol(input fc_sym_e code);
        return {FC_PREFIX, code, 1'b1};
    endfunction

    // Request codes with no defined meaning
    function automatic logic req_is_illegal(input logic [2:0] code);
        return (code == 3'd6) || (code == 3'd7);
    endfunction

endpackage

// File: rtl/hgcal_fast_control_scheduler_cmd_fifo.sv
// hgcal_fc_cmd_fifo: small synchronous FIFO holding pending slow commands.
// Push while full is honoured only when a pop happens in the same cycle.
module hgcal_fc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];
    assign pop_s  = pop & ~empty;
    assign push_s = push & (~full | pop_s);

    // Storage array; data needs no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hgcal_fast_control_scheduler.sv
// hgcal_fast_control_scheduler: owns the BX/orbit counters, generates
// OrbitSync, and merges queued slow commands with external L1As into one
// registered 8-bit fast-control symbol per 40 MHz BX.
// Optional feature macro: HGCAL_FC_CAL_AUTO_EN (automatic calibration L1A
// scheduled CAL_DELAY BX after each CalReq).
module hgcal_fast_control_scheduler
    import hgcal_fc_pkg::*;
#(
    parameter int ORBIT_LEN     = 3564,
    parameter int ORBIT_SYNC_BX = 0,
    parameter int PEND_DEPTH    = 4,
    parameter int CAL_DELAY     = 32,
    parameter int ORBIT_W       = 32
) (
    input  logic                              clk40,
    input  logic                              reset,
    input  logic                              l1a,
    input  logic                              cmd_valid,
    input  logic [2:0]                        cmd_code,
    output logic                              cmd_ready,
    output logic                              cmd_err,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   pend_count,
    output logic [7:0]                        fast_control,
    output logic [11:0]                       bx_counter,
    output logic [ORBIT_W-1:0]                orbit_counter
);

    localparam logic [11:0] LAST_BX = 12'(ORBIT_LEN - 1);
    localparam logic [11:0] SYNC_BX = 12'(ORBIT_SYNC_BX);

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [2:0]  fifo_dout_s;
    logic        fifo_push_s;
    logic        fifo_pop_s;

    logic        accept_s;
    logic        discard_s;
    logic        legal_in_s;
    logic        head_valid_s;
    logic [2:0]  head_code_s;

    logic        wrap_s;
    logic [11:0] next_bx_s;

    fc_sym_e     sym_s;
    logic        pop_s;
    logic        ocr_s;
    logic        cal_arm_s;
    logic        cal_fire_s;
    logic        cal_due_s;
    logic        cal_eligible_s;

    logic        cmd_err_r;
    logic [7:0]  fast_control_r;
    logic [11:0] bx_counter_r;
    logic [ORBIT_W-1:0] orbit_counter_r;

    // ------------------------------------------------------------------
    // Command intake. When the queue is empty a freshly accepted command
    // is visible as the head in the same cycle, so it can go out on the
    // very next symbol; it is only written into the FIFO if not served.
    // ------------------------------------------------------------------
    assign cmd_ready = ~reset & ~fifo_full_s;
    assign accept_s  = cmd_valid & cmd_ready;

`ifdef HGCAL_FC_CAL_AUTO_EN
    assign discard_s = accept_s & (req_is_illegal(cmd_code) | (cmd_code == REQ_CAL_L1A));
`else
    assign discard_s = accept_s & req_is_illegal(cmd_code);
`endif

    assign legal_in_s   = accept_s & ~discard_s;
    assign head_valid_s = ~fifo_empty_s | legal_in_s;
    assign head_code_s  = fifo_empty_s ? cmd_code : fifo_dout_s;
    assign fifo_pop_s   = pop_s & ~fifo_empty_s;
    assign fifo_push_s  = legal_in_s & ~(fifo_empty_s & pop_s);

    hgcal_fc_cmd_fifo #(
        .DEPTH (PEND_DEPTH),
        .WIDTH (3)
    ) u_cmd_fifo (
        .clk   (clk40),
        .rst   (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (cmd_code),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (pend_count)
    );

    // ------------------------------------------------------------------
    // BX sequencing: everything below is decided for the next BX.
    // ------------------------------------------------------------------
    assign wrap_s    = (bx_counter_r == LAST_BX);
    assign next_bx_s = wrap_s ? 12'd0 : bx_counter_r + 12'd1;

`ifdef HGCAL_FC_CAL_AUTO_EN
    logic        cal_pend_r;
    logic [11:0] cal_bx_r;
    logic [12:0] cal_sum_s;
    logic [11:0] cal_target_s;

    // The cal L1A of a CalReq sent now would land on this BX
    assign cal_sum_s    = {1'b0, next_bx_s} + 13'(CAL_DELAY);
    assign cal_target_s = (cal_sum_s >= 13'(ORBIT_LEN)) ? 12'(cal_sum_s - 13'(ORBIT_LEN))
                                                        : cal_sum_s[11:0];
    assign cal_due_s      = cal_pend_r & (cal_bx_r == next_bx_s);
    assign cal_eligible_s = ~cal_pend_r & (cal_target_s != SYNC_BX);

    // Calibration timer: one outstanding cal L1A, armed by CalReq
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            cal_pend_r <= 1'b0;
            cal_bx_r   <= 12'd0;
        end else if (cal_arm_s) begin
            cal_pend_r <= 1'b1;
            cal_bx_r   <= cal_target_s;
        end else if (cal_fire_s) begin
            cal_pend_r <= 1'b0;
            cal_bx_r   <= cal_bx_r;
        end else begin
            cal_pend_r <= cal_pend_r;
            cal_bx_r   <= cal_bx_r;
        end
    end
`else
    assign cal_due_s      = 1'b0;
    assign cal_eligible_s = 1'b1;
`endif

    // Per-BX symbol selection, first matching rule wins
    always_comb begin
        sym_s      = SYM_IDLE;
        pop_s      = 1'b0;
        ocr_s      = 1'b0;
        cal_arm_s  = 1'b0;
        cal_fire_s = 1'b0;
        if (next_bx_s == SYNC_BX) begin
            // OrbitSync slot: only an L1A or a pending OCR may share it
            if (l1a) begin
                sym_s = SYM_L1A_OS;
            end else if (head_valid_s && (head_code_s == REQ_ORBIT_COUNT_RESET)) begin
                sym_s = SYM_OCR_OS;
                pop_s = 1'b1;
                ocr_s = 1'b1;
            end else begin
                sym_s = SYM_ORBIT_SYNC;
            end
        end else if (cal_due_s) begin
            // A coincident l1a is absorbed into this symbol
            sym_s      = SYM_CAL_L1A_L1A;
            cal_fire_s = 1'b1;
        end else if (l1a) begin
            if (head_valid_s && (head_code_s == REQ_CAL_REQ) && cal_eligible_s) begin
                sym_s     = SYM_CAL_REQ_L1A;
                pop_s     = 1'b1;
                cal_arm_s = 1'b1;
            end else begin
                sym_s = SYM_L1A;
            end
        end else if (head_valid_s) begin
            case (head_code_s)
                REQ_LINK_RESET: begin
                    sym_s = SYM_LINK_RESET;
                    pop_s = 1'b1;
                end
                REQ_DAQ_RESYNC: begin
                    sym_s = SYM_DAQ_RESYNC;
                    pop_s = 1'b1;
                end
                REQ_CAL_REQ: begin
                    if (cal_eligible_s) begin
                        sym_s     = SYM_CAL_REQ;
                        pop_s     = 1'b1;
                        cal_arm_s = 1'b1;
                    end else begin
                        sym_s = SYM_IDLE;
                    end
                end
                REQ_INTERNAL_TEST: begin
                    sym_s = SYM_INTERNAL_TEST;
                    pop_s = 1'b1;
                end
                REQ_CAL_L1A: begin
                    sym_s = SYM_CAL_L1A_L1A;
                    pop_s = 1'b1;
                end
                default: begin
                    // OCR waits for the OrbitSync slot
                    sym_s = SYM_IDLE;
                end
            endcase
        end else begin
            sym_s = SYM_IDLE;
        end
    end

    // Symbol, BX and orbit advance together so they always describe one BX
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            fast_control_r  <= FC_IDLE_SYMBOL;
            bx_counter_r    <= 12'd0;
            orbit_counter_r <= {ORBIT_W{1'b0}};
            cmd_err_r       <= 1'b0;
        end else begin
            fast_control_r <= fc_symbol(sym_s);
            bx_counter_r   <= next_bx_s;
            cmd_err_r      <= discard_s;
            if (ocr_s) begin
                orbit_counter_r <= {ORBIT_W{1'b0}};
            end else if (wrap_s) begin
                orbit_counter_r <= orbit_counter_r + ORBIT_W'(1);
            end else begin
                orbit_counter_r <= orbit_counter_r;
            end
        end
    end

    assign fast_control  = fast_control_r;
    assign bx_counter    = bx_counter_r;
    assign orbit_counter = orbit_counter_r;
    assign cmd_err       = cmd_err_r;

endmodule

// File: tb/tb_hgcal_fast_control_scheduler.sv
// Bench for hgcal_fast_control_scheduler (ORBIT_LEN=16, sync BX 0,
// depth 4, CAL_DELAY 4). Expectations follow HGCAL_FC_CAL_AUTO_EN if set.
module tb_hgcal_fast_control_scheduler;

    localparam int ORBIT_LEN     = 16;
    localparam int ORBIT_SYNC_BX = 0;
    localparam int PEND_DEPTH    = 4;
    localparam int CAL_DELAY     = 4;
    localparam int ORBIT_W       = 32;
`ifdef HGCAL_FC_CAL_AUTO_EN
    localparam bit CAL_AUTO = 1'b1;
`else
    localparam bit CAL_AUTO = 1'b0;
`endif

    logic        clk40 = 1'b0;
    logic        reset = 1'b1;
    logic        l1a = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_code = 3'd0;
    logic        cmd_ready;
    logic        cmd_err;
    logic [2:0]  pend_count;
    logic [7:0]  fast_control;
    logic [11:0] bx_counter;
    logic [31:0] orbit_counter;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_bx = 0;
    logic [31:0] m_orbit = 32'd0;
    int          m_q[$];
    bit          m_cal_pend = 1'b0;
    int          m_cal_bx = 0;
    logic [7:0]  m_fc = 8'hC1;
    bit          m_err = 1'b0;

    hgcal_fast_control_scheduler #(
        .ORBIT_LEN     (ORBIT_LEN),
        .ORBIT_SYNC_BX (ORBIT_SYNC_BX),
        .PEND_DEPTH    (PEND_DEPTH),
        .CAL_DELAY     (CAL_DELAY),
        .ORBIT_W       (ORBIT_W)
    ) dut (
        .clk40         (clk40),
        .reset         (reset),
        .l1a           (l1a),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .cmd_ready     (cmd_ready),
        .cmd_err       (cmd_err),
        .pend_count    (pend_count),
        .fast_control  (fast_control),
        .bx_counter    (bx_counter),
        .orbit_counter (orbit_counter)
    );

    always #5 clk40 = ~clk40;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sym(input int code);
        logic [3:0] c;
        c = code[3:0];
        return {3'b110, c, 1'b1};
    endfunction

    function automatic bit cal_ok(input int n);
        if (!CAL_AUTO) return 1'b1;
        return !m_cal_pend && (((n + CAL_DELAY) % ORBIT_LEN) != ORBIT_SYNC_BX);
    endfunction

    task automatic model_reset();
        m_bx = 0; m_orbit = 32'd0; m_q.delete();
        m_cal_pend = 1'b0; m_cal_bx = 0; m_fc = 8'hC1; m_err = 1'b0;
    endtask

    // One BX of the reference: apply the priority rules to the next BX
    task automatic model_step();
        int n; bit acc; bit disc; int head; int c; bit pop; bit ocr; bit arm;
        n    = (m_bx + 1) % ORBIT_LEN;
        acc  = cmd_valid && (m_q.size() < PEND_DEPTH);
        disc = acc && ((cmd_code >= 3'd6) || (CAL_AUTO && cmd_code == 3'd5));
        if (acc && !disc) m_q.push_back(int'(cmd_code));
        head = (m_q.size() > 0) ? m_q[0] : -1;
        c = 0; pop = 0; ocr = 0; arm = 0;
        if (n == ORBIT_SYNC_BX) begin
            if (l1a) c = 5;
            else if (head == 4) begin c = 7; pop = 1; ocr = 1; end
            else c = 1;
        end else if (CAL_AUTO && m_cal_pend && n == m_cal_bx) begin
            c = 10; m_cal_pend = 0;
        end else if (l1a) begin
            if (head == 2 && cal_ok(n)) begin c = 9; pop = 1; arm = 1; end
            else c = 4;
        end else begin
            case (head)
                0: begin c = 15; pop = 1; end
                1: begin c = 2;  pop = 1; end
                2: if (cal_ok(n)) begin c = 8; pop = 1; arm = 1; end
                3: begin c = 11; pop = 1; end
                5: begin c = 10; pop = 1; end
                default: c = 0;
            endcase
        end
        if (arm && CAL_AUTO) begin
            m_cal_pend = 1; m_cal_bx = (n + CAL_DELAY) % ORBIT_LEN;
        end
        if (pop) void'(m_q.pop_front());
        if (ocr) m_orbit = 32'd0;
        else if (n == 0) m_orbit = m_orbit + 32'd1;
        m_bx = n;
        m_fc = sym(c);
        m_err = disc;
    endtask

    task automatic compare_all();
        check("fast_control", {24'd0, fast_control}, {24'd0, m_fc});
        check("bx_counter", {20'd0, bx_counter}, m_bx);
        check("orbit_counter", orbit_counter, m_orbit);
        check("pend_count", {29'd0, pend_count}, m_q.size());
        check("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, (!reset && m_q.size() < PEND_DEPTH)});
    endtask

    task automatic tick();
        @(posedge clk40);
        if (reset) model_reset(); else model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic a, input logic v, input logic [2:0] code);
        l1a = a; cmd_valid = v; cmd_code = code;
        tick();
        l1a = 1'b0; cmd_valid = 1'b0; cmd_code = 3'd0;
    endtask

    task automatic advance_to(input int target);
        int guard;
        guard = 0;
        while (m_bx != target && guard < 2 * ORBIT_LEN) begin
            tick();
            guard++;
        end
        check("advance_bound", {31'd0, (m_bx == target)}, 32'd1);
    endtask

    typedef struct {
        logic        a;
        logic        v;
        logic [2:0]  code;
        logic [7:0]  fc;
        logic [11:0] bx;
        logic [2:0]  pend;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // directed table, starting right after reset release (BX 0)
        tbl[0] = '{1'b0, 1'b0, 3'd0, 8'hC1, 12'd1,  3'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'd0, 8'hC9, 12'd2,  3'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 3'd0, 8'hDF, 12'd3,  3'd0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 3'd1, 8'hC9, 12'd4,  3'd1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 3'd0, 8'hC5, 12'd5,  3'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 3'd3, 8'hD7, 12'd6,  3'd0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 3'd7, 8'hC1, 12'd7,  3'd0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 3'd0, 8'hC1, 12'd8,  3'd0, 1'b0};
        if (CAL_AUTO) tbl[8] = '{1'b0, 1'b1, 3'd5, 8'hC1, 12'd9, 3'd0, 1'b1};
        else          tbl[8] = '{1'b0, 1'b1, 3'd5, 8'hD5, 12'd9, 3'd0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 3'd0, 8'hC1, 12'd10, 3'd0, 1'b0};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("reset_fc", {24'd0, fast_control}, 32'h000000C1);
        check("reset_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].v, tbl[i].code);
            check("tbl_fc", {24'd0, fast_control}, {24'd0, tbl[i].fc});
            check("tbl_bx", {20'd0, bx_counter}, {20'd0, tbl[i].bx});
            check("tbl_pend", {29'd0, pend_count}, {29'd0, tbl[i].pend});
            check("tbl_err", {31'd0, cmd_err}, {31'd0, tbl[i].err});
        end

        // idle orbit wrap: OrbitSync at BX 0 and orbit increments
        advance_to(15);
        tick();
        check("os_fc", {24'd0, fast_control}, 32'h000000C3);
        check("os_orbit", orbit_counter, 32'd1);

        // OCR queued, l1a takes the sync slot, OCR goes next orbit
        drive(1'b0, 1'b1, 3'd4);
        check("ocr_pend", {29'd0, pend_count}, 32'd1);
        advance_to(15);
        drive(1'b1, 1'b0, 3'd0);
        check("l1a_os_fc", {24'd0, fast_control}, 32'h000000CB);
        check("l1a_os_orbit", orbit_counter, 32'd2);
        check("ocr_held", {29'd0, pend_count}, 32'd1);
        advance_to(15);
        tick();
        check("ocr_os_fc", {24'd0, fast_control}, 32'h000000CF);
        check("ocr_orbit", orbit_counter, 32'd0);

        // CalReq at BX 5, cal L1A at BX 10 merging an l1a from BX 9
        advance_to(5);
        drive(1'b0, 1'b1, 3'd2);
        check("calreq_fc", {24'd0, fast_control}, 32'h000000D1);
        advance_to(9);
        drive(1'b1, 1'b0, 3'd0);
        check("cal_l1a_fc", {24'd0, fast_control}, CAL_AUTO ? 32'h000000D5 : 32'h000000C9);

        // CalReq whose cal BX would hit the sync BX, LinkReset behind it
        advance_to(11);
        drive(1'b0, 1'b1, 3'd2);
        check("calreq_hold_fc", {24'd0, fast_control}, CAL_AUTO ? 32'h000000C1 : 32'h000000D1);
        drive(1'b0, 1'b1, 3'd0);
        check("calreq_late_fc", {24'd0, fast_control}, CAL_AUTO ? 32'h000000D1 : 32'h000000DF);
        tick();
        check("lr_after_fc", {24'd0, fast_control}, CAL_AUTO ? 32'h000000DF : 32'h000000C1);

        // fill the queue behind a blocking OCR
        advance_to(1);
        drive(1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b1, 3'd0);
        drive(1'b0, 1'b1, 3'd0);
        drive(1'b0, 1'b1, 3'd7);
        check("illegal_err", {31'd0, cmd_err}, 32'd1);
        check("illegal_pend", {29'd0, pend_count}, 32'd3);
        drive(1'b0, 1'b1, 3'd0);
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        check("full_pend", {29'd0, pend_count}, 32'd4);
        drive(1'b0, 1'b1, 3'd1);
        check("full_hold", {29'd0, pend_count}, 32'd4);

        // asynchronous reset mid-run
        #2;
        reset = 1'b1;
        #1;
        check("arst_fc", {24'd0, fast_control}, 32'h000000C1);
        check("arst_bx", {20'd0, bx_counter}, 32'd0);
        check("arst_orbit", orbit_counter, 32'd0);
        check("arst_pend", {29'd0, pend_count}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd0);
        model_reset();
        tick();
        reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0),
                  3'($urandom_range(7, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
